operand_sort_stage: RTL

// Registered pre-align stage of the FP add/sub pipeline. Per accepted operation it decides

---
 rtl/operand_sort_stage.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/operand_sort_stage.sv
// Pre-align stage of the FP add/sub pipeline: orders the operands by magnitude,
// computes the saturated alignment shift and the effective operation, and
// buffers results in a two-entry skid buffer so in_ready comes from a register.

module operand_exchanger (
  input  logic        exchange,
  input  logic        sign_a,
  input  logic        sign_b,
  input  logic [7:0]  exp_a,
  input  logic [7:0]  exp_b,
  input  logic [23:0] frac_a,
  input  logic [23:0] frac_b,
  output logic        sorted_sign_a,
  output logic        sorted_sign_b,
  output logic [7:0]  sorted_exp_a,
  output logic [7:0]  sorted_exp_b,
  output logic [23:0] sorted_frac_a,
  output logic [23:0] sorted_frac_b
);

  // Swap both operands as a unit when asked; otherwise pass straight through.
  always_comb begin
    if (exchange) begin
      sorted_sign_a = sign_b;
      sorted_sign_b = sign_a;
      sorted_exp_a  = exp_b;
      sorted_exp_b  = exp_a;
      sorted_frac_a = frac_b;
      sorted_frac_b = frac_a;
    end else begin
      sorted_sign_a = sign_a;
      sorted_sign_b = sign_b;
      sorted_exp_a  = exp_a;
      sorted_exp_b  = exp_b;
      sorted_frac_a = frac_a;
      sorted_frac_b = frac_b;
    end
  end

endmodule

module operand_sort_stage #(
  parameter int TAG_WIDTH = 4,
  parameter int SHIFT_SAT = 26,
  localparam int SW = $clog2(SHIFT_SAT + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_subtract,
  input  logic                 in_sign_a,
  input  logic                 in_sign_b,
  input  logic [7:0]           in_exponent_a,
  input  logic [7:0]           in_exponent_b,
  input  logic [23:0]          in_fraction_a,
  input  logic [23:0]          in_fraction_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign_a,
  output logic                 out_sign_b,
  output logic [7:0]           out_exponent_a,
  output logic [7:0]           out_exponent_b,
  output logic [23:0]          out_fraction_a,
  output logic [23:0]          out_fraction_b,
  output logic [SW-1:0]        out_shift,
  output logic                 out_eff_sub,
  output logic                 out_swapped,
  output logic [TAG_WIDTH-1:0] out_tag
);

  typedef struct packed {
    logic                 sign_a;
    logic                 sign_b;
    logic [7:0]           exp_a;
    logic [7:0]           exp_b;
    logic [23:0]          frac_a;
    logic [23:0]          frac_b;
    logic [SW-1:0]        shift;
    logic                 eff_sub;
    logic                 swapped;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // The sorted exponent difference is never negative; clamp it to the
  // largest shift the alignment shifter can use.
  function automatic logic [SW-1:0] sat_shift(input logic [7:0] diff);
    if (int'(diff) > SHIFT_SAT) return SW'(SHIFT_SAT);
    return SW'(diff);
  endfunction

  logic        sign_b_eff_p0;
  logic        exchange_p0;
  logic        sorted_sign_a_p0;
  logic        sorted_sign_b_p0;
  logic [7:0]  sorted_exp_a_p0;
  logic [7:0]  sorted_exp_b_p0;
  logic [23:0] sorted_frac_a_p0;
  logic [23:0] sorted_frac_b_p0;
  logic [7:0]  exp_diff_p0;
  entry_t      ent_p0;

  entry_t      main_p1;
  entry_t      skid_p1;
  state_t      state;
  state_t      next_state;
  logic        accept;
  logic        pop;
  logic        load_main_in;
  logic        load_skid_in;
  logic        skid_to_main;

  // ---- stage p0: sort decision and derived fields (combinational) ----
  assign sign_b_eff_p0 = in_sign_b ^ in_subtract;
  assign exchange_p0   = {in_exponent_b, in_fraction_b} > {in_exponent_a, in_fraction_a};

  operand_exchanger u_exchanger (
    .exchange      (exchange_p0),
    .sign_a        (in_sign_a),
    .sign_b        (sign_b_eff_p0),
    .exp_a         (in_exponent_a),
    .exp_b         (in_exponent_b),
    .frac_a        (in_fraction_a),
    .frac_b        (in_fraction_b),
    .sorted_sign_a (sorted_sign_a_p0),
    .sorted_sign_b (sorted_sign_b_p0),
    .sorted_exp_a  (sorted_exp_a_p0),
    .sorted_exp_b  (sorted_exp_b_p0),
    .sorted_frac_a (sorted_frac_a_p0),
    .sorted_frac_b (sorted_frac_b_p0)
  );

  assign exp_diff_p0 = sorted_exp_a_p0 - sorted_exp_b_p0;

  // Pack the sorted operation into one buffer entry.
  always_comb begin
    ent_p0         = '0;
    ent_p0.sign_a  = sorted_sign_a_p0;
    ent_p0.sign_b  = sorted_sign_b_p0;
    ent_p0.exp_a   = sorted_exp_a_p0;
    ent_p0.exp_b   = sorted_exp_b_p0;
    ent_p0.frac_a  = sorted_frac_a_p0;
    ent_p0.frac_b  = sorted_frac_b_p0;
    ent_p0.shift   = sat_shift(exp_diff_p0);
    ent_p0.eff_sub = sorted_sign_a_p0 ^ sorted_sign_b_p0;
    ent_p0.swapped = exchange_p0;
    ent_p0.tag     = in_tag;
  end

  // ---- stage p1: two-entry skid buffer ----
  // Both handshake outputs decode the state register only, so no
  // combinational path runs from out_ready to in_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Occupancy state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= next_state;
  end

  // Next occupancy and data-movement strobes; flush wins over everything.
  always_comb begin
    next_state   = state;
    load_main_in = 1'b0;
    load_skid_in = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            next_state   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            next_state   = FULL;
            load_skid_in = 1'b1;
          end else if (pop) begin
            next_state = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            next_state   = ONE;
            skid_to_main = 1'b1;
          end
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  // Entry data; cleared on reset so outputs read zero until the first accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_main_in)      main_p1 <= ent_p0;
      else if (skid_to_main) main_p1 <= skid_p1;
      if (load_skid_in)      skid_p1 <= ent_p0;
    end
  end

  assign out_sign_a     = main_p1.sign_a;
  assign out_sign_b     = main_p1.sign_b;
  assign out_exponent_a = main_p1.exp_a;
  assign out_exponent_b = main_p1.exp_b;
  assign out_fraction_a = main_p1.frac_a;
  assign out_fraction_b = main_p1.frac_b;
  assign out_shift      = main_p1.shift;
  assign out_eff_sub    = main_p1.eff_sub;
  assign out_swapped    = main_p1.swapped;
  assign out_tag        = main_p1.tag;

endmodule
